red_pitaya_fads_mc: RTL and testbench
=====================================

// Module: red_pitaya_fads_mc
// PURPOSE
// Multi-channel fluorescence-activated droplet sorter. Detects droplets on ADC channel 0,
// measures width and per-channel peak intensity, classifies each droplet against
// bus-programmed windows and fires a timed sort pulse on sort_trig toward the ASG/HV path.
// Sits between the ADC front end and the ASG trigger mux; configured over the sys bus.
// PARAMETERS
// NCH  2   number of ADC channels evaluated (1..4); channel 0 is also the detect channel
// DW   14  ADC sample width, signed two's complement
// CW   32  width of timers, pulse lengths and counters
// PORTS
// adc_clk_i   in   1       ADC clock, sole clock
// adc_rst_i   in   1       asynchronous reset, active-high
// adc_i       in   NCH*DW  signed samples, channel n at [n*DW +: DW]
// sort_trig   out  1       sort pulse to ASG trigger, registered
// sys_addr    in   32      bus address (decode [19:0])
// sys_wdata   in   32      bus write data
// sys_sel     in   4       byte select (ignored, full-word writes)
// sys_wen     in   1       bus write enable
// sys_ren     in   1       bus read enable
// sys_rdata   out  32      bus read data
// sys_err     out  1       bus error, constant 0
// sys_ack     out  1       bus acknowledge
// BEHAVIOUR
// - One clock adc_clk_i; reset asynchronous, active-high (adc_rst_i).
// - Reset: sort_trig=0, sys_ack=0, sys_err=0, sys_rdata=0, state IDLE, counters 0, enable=0,
//   min_int=15, low_int[n]=15, high_int[n]=255, min_width=1, low_width=0, high_width=2^CW-1,
//   sort_delay=0, sort_len=1. All intensity compares are signed.
// - detect = ch0 >= min_int. armed set when !detect; cleared on entry to MEASURE.
// - States: IDLE -> MEASURE when enable & armed & detect. MEASURE: width+=1 (saturate at
//   2^CW-1), peak[n]=max(peak[n],ch n); peaks load first sample on entry. MEASURE -> EVAL
//   on first !detect sample. EVAL (1 cycle): if width<min_width: short_cnt++, -> IDLE;
//   else drop_cnt++; positive iff low_width<=width<high_width and for all n
//   low_int[n]<=peak[n]<high_int[n]; positive: pos_cnt++, -> DELAY, else -> IDLE.
//   DELAY counts sort_delay cycles (0 = pass through in 1 cycle) -> FIRE. FIRE holds
//   sort_len cycles (0 treated as 1) -> IDLE.
// - sort_trig = registered (state==FIRE): rises sort_delay+2 cycles after the first !detect
//   sample edge; high exactly max(sort_len,1) cycles.
// - Droplets arriving during DELAY/FIRE are not measured; armed requires a !detect sample
//   before next MEASURE, so a droplet straddling IDLE entry is skipped.
// - enable cleared in any state: -> IDLE next cycle, sort_trig 0 next cycle, no count update.
// - Counters saturate at 2^CW-1. ctrl.clr (self-clearing) zeroes counters; clr and an EVAL
//   increment in the same cycle: clear wins.
// - Bus: sys_ack pulses 1 cycle after sys_wen|sys_ren; writes to RO/unmapped ignored;
//   unmapped reads return 0. Threshold writes take effect next cycle, including mid-droplet.
// CONFIGURATION
// Register map (byte addr): 0x00 ctrl[0]=enable,[1]=clr(WO); 0x04 min_int; 0x08 min_width;
// 0x0C low_width; 0x10 high_width; 0x14 sort_delay; 0x18 sort_len; 0x1C drop_cnt(RO);
// 0x20 pos_cnt(RO); 0x24 short_cnt(RO); 0x28 state(RO, IDLE=0..FIRE=4);
// 0x40+8n low_int[n]; 0x44+8n high_int[n]. Intensity reads sign-extended to 32 bits.
// Optional macro FADS_SORT_DELAY_EN:
// - defined: 0x14 read/write, DELAY state as above.
// - undefined: 0x14 reads 0, writes ignored; EVAL -> FIRE directly; sort_trig rises
//   2 cycles after first !detect sample. DELAY state encoding retained but unreachable.
// TESTING
// 1 enable=1, min_int=15, windows default, ch0=100 for 20 cycles then 0 -> drop_cnt=1,
//   pos_cnt=1, sort_trig high 1 cycle, rising 2 cycles after ch0 falls (delay 0).
// 2 sort_delay=50, sort_len=10, same droplet -> sort_trig rises 52 cycles after fall,
//   high 10 cycles (macro defined); macro undefined -> rises after 2 cycles.
// 3 NCH=2, high_int[1]=255, ch1=300 during droplet -> drop_cnt=1, pos_cnt=0, no trigger;
//   ch0=-20, min_int=-30 droplet -> detected (signed compare).
// 4 min_width=5, droplet 3 samples -> short_cnt=1, drop_cnt=0; high_width=10, 12-sample
//   droplet -> drop_cnt=1, pos_cnt=0.
// 5 clear enable mid-MEASURE and mid-FIRE -> IDLE next cycle, sort_trig 0, counters unchanged;
//   ch0 held high across re-enable -> no detection until ch0 drops below min_int.
// 6 adc_rst_i asserted mid-FIRE -> sort_trig 0 immediately, all registers at reset values;
//   clr coincident with EVAL -> counters read 0.

Source files
------------

// File: rtl/red_pitaya_fads_mc.sv
// Multi-channel fluorescence-activated droplet sorter.
// Detects droplets on ADC channel 0, measures width and per-channel peaks,
// classifies against bus-programmed windows and fires a timed sort pulse.
// Optional macro FADS_SORT_DELAY_EN enables the programmable sort delay
// (register 0x14 and the DELAY state); without it EVAL goes straight to FIRE.
`timescale 1ns/1ps

module red_pitaya_fads_mc #(
  parameter int unsigned NCH = 2,
  parameter int unsigned DW  = 14,
  parameter int unsigned CW  = 32
) (
  input  logic              adc_clk_i,
  input  logic              adc_rst_i,
  input  logic [NCH*DW-1:0] adc_i,
  output logic              sort_trig,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic [3:0]        sys_sel,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam int unsigned TW = CW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    EVAL    = 3'd2,
    DELAY   = 3'd3,
    FIRE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                 enable;
  logic signed [DW-1:0] min_int;
  logic [CW-1:0]        min_width, low_width, high_width, sort_delay, sort_len;
  logic [CW-1:0]        drop_cnt, pos_cnt, short_cnt;
  logic [CW-1:0]        width, tmr;
  logic signed [DW-1:0] low_int  [NCH];
  logic signed [DW-1:0] high_int [NCH];
  logic signed [DW-1:0] peak     [NCH];
  logic signed [DW-1:0] ch       [NCH];
  logic                 armed;

  logic [19:0]   addr;
  logic          ctrl_clr;
  logic          detect;
  logic          int_ok;
  logic          width_short;
  logic          positive;
  logic [CW-1:0] len_eff;
  logic [TW-1:0] tmr_inc;
  logic [31:0]   rdata_nxt;
  logic          unused_bits;

  function automatic logic [19:0] int_addr(input int n, input logic hi);
    return 20'(32'h40 + 32'(8 * n) + (hi ? 32'd4 : 32'd0));
  endfunction

  function automatic logic [31:0] sext(input logic signed [DW-1:0] v);
    return {{(32 - DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (&x) ? x : x + CW'(1);
  endfunction

  assign addr        = sys_addr[19:0];
  assign ctrl_clr    = sys_wen && (addr == 20'h00) && sys_wdata[1];
  assign sys_err     = 1'b0;
  assign unused_bits = ^{sys_sel, sys_addr[31:20]};

  // Unpack channels and evaluate detect / classification terms
  always_comb begin
    int_ok = 1'b1;
    for (int n = 0; n < int'(NCH); n++) begin
      ch[n] = adc_i[n*DW +: DW];
      if (!((peak[n] >= low_int[n]) && (peak[n] < high_int[n]))) int_ok = 1'b0;
    end
    detect      = (ch[0] >= min_int);
    width_short = (width < min_width);
    positive    = (width >= low_width) && (width < high_width) && int_ok;
    len_eff     = (sort_len == '0) ? CW'(1) : sort_len;
    tmr_inc     = {1'b0, tmr} + TW'(1);
  end

  // State register
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; losing enable forces IDLE from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && armed && detect) state_nxt = MEASURE;
      MEASURE: if (!detect) state_nxt = EVAL;
      EVAL: begin
        if (!width_short && positive) begin
`ifdef FADS_SORT_DELAY_EN
          state_nxt = (sort_delay == '0) ? FIRE : DELAY;
`else
          state_nxt = FIRE;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      DELAY:   if (tmr_inc >= {1'b0, sort_delay}) state_nxt = FIRE;
      FIRE:    if (tmr_inc >= {1'b0, len_eff}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Width/peak capture, DELAY/FIRE timer and re-arm tracking
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      width <= '0;
      tmr   <= '0;
      armed <= 1'b0;
      for (int n = 0; n < int'(NCH); n++) peak[n] <= '0;
    end else begin
      if (state != state_nxt)                    tmr <= '0;
      else if ((state == DELAY) || (state == FIRE)) tmr <= tmr + CW'(1);

      if ((state == IDLE) && (state_nxt == MEASURE)) begin
        width <= CW'(1);
        for (int n = 0; n < int'(NCH); n++) peak[n] <= ch[n];
      end else if ((state == MEASURE) && detect) begin
        width <= sat_inc(width);
        for (int n = 0; n < int'(NCH); n++)
          if (ch[n] > peak[n]) peak[n] <= ch[n];
      end

      // Only a below-threshold sample seen while idle and enabled arms detection
      if (!enable || (state != IDLE) || (state_nxt == MEASURE)) armed <= 1'b0;
      else if (!detect)                                       armed <= 1'b1;
    end
  end

  // Droplet statistics; a clear coinciding with EVAL wins
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      drop_cnt  <= '0;
      pos_cnt   <= '0;
      short_cnt <= '0;
    end else if (ctrl_clr) begin
      drop_cnt  <= '0;
      pos_cnt   <= '0;
      short_cnt <= '0;
    end else if ((state == EVAL) && enable) begin
      if (width_short) begin
        short_cnt <= sat_inc(short_cnt);
      end else begin
        drop_cnt <= sat_inc(drop_cnt);
        if (positive) pos_cnt <= sat_inc(pos_cnt);
      end
    end
  end

  // Sort pulse follows FIRE one cycle later and drops at once when disabled
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) sort_trig <= 1'b0;
    else           sort_trig <= (state == FIRE) && enable;
  end

  // Bus-writable configuration
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      enable     <= 1'b0;
      min_int    <= DW'(15);
      min_width  <= CW'(1);
      low_width  <= '0;
      high_width <= '1;
      sort_len   <= CW'(1);
      for (int n = 0; n < int'(NCH); n++) begin
        low_int[n]  <= DW'(15);
        high_int[n] <= DW'(255);
      end
    end else if (sys_wen) begin
      case (addr)
        20'h00:  enable     <= sys_wdata[0];
        20'h04:  min_int    <= sys_wdata[DW-1:0];
        20'h08:  min_width  <= CW'(sys_wdata);
        20'h0C:  low_width  <= CW'(sys_wdata);
        20'h10:  high_width <= CW'(sys_wdata);
        20'h18:  sort_len   <= CW'(sys_wdata);
        default: ;
      endcase
      for (int n = 0; n < int'(NCH); n++) begin
        if (addr == int_addr(n, 1'b0)) low_int[n]  <= sys_wdata[DW-1:0];
        if (addr == int_addr(n, 1'b1)) high_int[n] <= sys_wdata[DW-1:0];
      end
    end
  end

`ifdef FADS_SORT_DELAY_EN
  // Programmable delay between classification and sort pulse
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i)                        sort_delay <= '0;
    else if (sys_wen && (addr == 20'h14)) sort_delay <= CW'(sys_wdata);
  end
`else
  assign sort_delay = '0;
`endif

  // Read mux
  always_comb begin
    rdata_nxt = '0;
    case (addr)
      20'h00:  rdata_nxt = {31'd0, enable};
      20'h04:  rdata_nxt = sext(min_int);
      20'h08:  rdata_nxt = 32'(min_width);
      20'h0C:  rdata_nxt = 32'(low_width);
      20'h10:  rdata_nxt = 32'(high_width);
      20'h14:  rdata_nxt = 32'(sort_delay);
      20'h18:  rdata_nxt = 32'(sort_len);
      20'h1C:  rdata_nxt = 32'(drop_cnt);
      20'h20:  rdata_nxt = 32'(pos_cnt);
      20'h24:  rdata_nxt = 32'(short_cnt);
      20'h28:  rdata_nxt = 32'(state);
      default: rdata_nxt = '0;
    endcase
    for (int n = 0; n < int'(NCH); n++) begin
      if (addr == int_addr(n, 1'b0)) rdata_nxt = sext(low_int[n]);
      if (addr == int_addr(n, 1'b1)) rdata_nxt = sext(high_int[n]);
    end
  end

  // Bus response: one-cycle acknowledge, registered read data
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren) sys_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_red_pitaya_fads_mc.sv
// Scoreboard bench for red_pitaya_fads_mc: bus reads and sort pulses are
// predicted when issued and checked by independent monitors.
`timescale 1ns/1ps

module tb_red_pitaya_fads_mc;

  localparam int NCH = 2;
  localparam int DW  = 14;
  localparam int CW  = 32;
`ifdef FADS_SORT_DELAY_EN
  localparam int          EXP_D    = 50;
  localparam logic [31:0] EXP_DREG = 32'd50;
`else
  localparam int          EXP_D    = 0;
  localparam logic [31:0] EXP_DREG = 32'd0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] a0 = '0;
  logic signed [DW-1:0] a1 = '0;
  logic [NCH*DW-1:0]    adc;
  logic                 sort_trig;
  logic [31:0]          sys_addr  = '0;
  logic [31:0]          sys_wdata = '0;
  logic [3:0]           sys_sel   = 4'hF;
  logic                 sys_wen   = 1'b0;
  logic                 sys_ren   = 1'b0;
  logic [31:0]          sys_rdata;
  logic                 sys_err;
  logic                 sys_ack;

  assign adc = {a1, a0};

  red_pitaya_fads_mc #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .adc_clk_i (clk),
    .adc_rst_i (rst),
    .adc_i     (adc),
    .sort_trig (sort_trig),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bus_exp_q  [$];
  bit          bus_read_q [$];
  string       bus_name_q [$];
  int          rise_q     [$];
  int          len_q      [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: every acknowledge retires one issued access
  always @(negedge clk) begin
    if (!rst && sys_ack) begin
      if (bus_read_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with no access outstanding (cycle %0d)", cyc);
      end else begin
        logic [31:0] e;
        bit          r;
        string       nm;
        e  = bus_exp_q.pop_front();
        r  = bus_read_q.pop_front();
        nm = bus_name_q.pop_front();
        if (r) check(nm, sys_rdata, e);
      end
    end
  end

  // Sort pulse monitor: measures rise cycle and length of each pulse
  bit trig_prev = 1'b0;
  int trig_rise = 0;
  int trig_len  = 0;
  always @(negedge clk) begin
    if (sort_trig && !trig_prev) begin
      trig_rise = cyc;
      trig_len  = 1;
    end else if (sort_trig) begin
      trig_len++;
    end else if (trig_prev) begin
      if (rise_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: rise %0d len %0d, none required", trig_rise, trig_len);
      end else begin
        check("pulse_rise", 32'(trig_rise), 32'(rise_q.pop_front()));
        check("pulse_len", 32'(trig_len), 32'(len_q.pop_front()));
      end
    end
    trig_prev = sort_trig;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_exp_q.push_back('0);
    bus_read_q.push_back(1'b0);
    bus_name_q.push_back("wr");
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    bus_exp_q.push_back(e);
    bus_read_q.push_back(1'b1);
    bus_name_q.push_back(nm);
    sys_addr = a;
    sys_ren  = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
  endtask

  // Drive n above-threshold samples, then return to base; fall = edge sampling the first low sample
  task automatic droplet(input int v0, input int v1, input int n, input int base0, output int fall);
    a0 = DW'(v0);
    a1 = DW'(v1);
    repeat (n) @(negedge clk);
    a0 = DW'(base0);
    a1 = '0;
    fall = cyc + 1;
  endtask

  task automatic expect_pulse(input int rise, input int len);
    rise_q.push_back(rise);
    len_q.push_back(len);
  endtask

  initial begin
    int f;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trig", {31'd0, sort_trig}, 32'd0);
    check("rst_ack", {31'd0, sys_ack}, 32'd0);
    check("rst_rdata", sys_rdata, 32'd0);
    check("rst_err", {31'd0, sys_err}, 32'd0);
    rst = 1'b0;
    idle(1);
    bus_rd(32'h28, 32'd0, "rst_state");
    bus_rd(32'h18, 32'd1, "rst_sort_len");

    // Basic positive droplet, default windows
    bus_wr(32'h00, 32'd1);
    idle(3);
    droplet(100, 100, 20, 0, f);
    expect_pulse(f + 2, 1);
    idle(10);
    bus_rd(32'h1C, 32'd1, "t1_drop");
    bus_rd(32'h20, 32'd1, "t1_pos");
    bus_rd(32'h24, 32'd0, "t1_short");

    // Sort delay and pulse length
    bus_wr(32'h14, 32'd50);
    bus_wr(32'h18, 32'd10);
    bus_rd(32'h14, EXP_DREG, "t2_delay_reg");
    idle(2);
    droplet(100, 100, 20, 0, f);
    expect_pulse(f + EXP_D + 2, 10);
    idle(75);
    bus_rd(32'h1C, 32'd2, "t2_drop");
    bus_rd(32'h20, 32'd2, "t2_pos");
    bus_wr(32'h14, 32'd0);
    bus_wr(32'h18, 32'd1);

    // Channel 1 above its high window -> negative
    bus_wr(32'h4C, 32'd255);
    bus_rd(32'h4C, 32'd255, "t3_high1");
    idle(2);
    droplet(100, 300, 8, 0, f);
    idle(5);
    bus_rd(32'h1C, 32'd3, "t3_drop");
    bus_rd(32'h20, 32'd2, "t3_pos");

    // Negative threshold, signed detection
    a0 = -14'sd100;
    bus_wr(32'h04, 32'hFFFF_FFE2);
    bus_rd(32'h04, 32'hFFFF_FFE2, "t3_min_int_sext");
    idle(3);
    droplet(-20, 100, 6, -100, f);
    idle(5);
    bus_rd(32'h1C, 32'd4, "t3_signed_drop");
    bus_rd(32'h20, 32'd2, "t3_signed_pos");
    bus_wr(32'h04, 32'd15);
    a0 = '0;
    idle(3);

    // Width windows
    bus_wr(32'h08, 32'd5);
    idle(2);
    droplet(100, 100, 3, 0, f);
    idle(5);
    bus_rd(32'h24, 32'd1, "t4_short");
    bus_rd(32'h1C, 32'd4, "t4_short_drop");
    bus_wr(32'h10, 32'd10);
    idle(2);
    droplet(100, 100, 12, 0, f);
    idle(5);
    bus_rd(32'h1C, 32'd5, "t4_wide_drop");
    bus_rd(32'h20, 32'd2, "t4_wide_pos");
    droplet(100, 100, 9, 0, f);
    expect_pulse(f + 2, 1);
    idle(6);
    bus_rd(32'h1C, 32'd6, "t4_edge_drop");
    bus_rd(32'h20, 32'd3, "t4_edge_pos");
    bus_wr(32'h10, 32'hFFFF_FFFF);
    bus_wr(32'h08, 32'd1);

    // Disable mid-MEASURE, re-enable with ch0 held high
    bus_wr(32'h18, 32'd10);
    idle(2);
    a0 = 14'sd100;
    a1 = 14'sd100;
    idle(5);
    bus_wr(32'h00, 32'd0);
    idle(1);
    bus_rd(32'h28, 32'd0, "t5_state_after_disable");
    idle(8);
    bus_wr(32'h00, 32'd1);
    idle(10);
    bus_rd(32'h28, 32'd0, "t5_state_held_high");
    a0 = '0;
    a1 = '0;
    idle(5);
    bus_rd(32'h1C, 32'd6, "t5_drop_unchanged");
    bus_rd(32'h24, 32'd1, "t5_short_unchanged");

    // Disable mid-FIRE truncates the pulse
    idle(2);
    droplet(100, 100, 5, 0, f);
    r = f + 2;
    expect_pulse(r, 4);
    while (cyc < r + 2) @(negedge clk);
    bus_wr(32'h00, 32'd0);
    idle(1);
    bus_rd(32'h28, 32'd0, "t5_fire_state");
    bus_rd(32'h1C, 32'd7, "t5_fire_drop");
    bus_rd(32'h20, 32'd4, "t5_fire_pos");
    bus_wr(32'h00, 32'd1);
    idle(3);

    // Asynchronous reset mid-FIRE
    droplet(100, 100, 5, 0, f);
    r = f + 2;
    expect_pulse(r, 3);
    while (cyc < r + 2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t6_trig_async", {31'd0, sort_trig}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    bus_rd(32'h00, 32'd0, "t6_ctrl");
    bus_rd(32'h04, 32'd15, "t6_min_int");
    bus_rd(32'h08, 32'd1, "t6_min_width");
    bus_rd(32'h10, 32'hFFFF_FFFF, "t6_high_width");
    bus_rd(32'h18, 32'd1, "t6_sort_len");
    bus_rd(32'h40, 32'd15, "t6_low_int0");
    bus_rd(32'h4C, 32'd255, "t6_high_int1");
    bus_rd(32'h1C, 32'd0, "t6_drop");
    bus_rd(32'h20, 32'd0, "t6_pos");
    bus_rd(32'h28, 32'd0, "t6_state");

    // Clear coincident with EVAL
    bus_wr(32'h00, 32'd1);
    idle(3);
    droplet(100, 100, 5, 0, f);
    expect_pulse(f + 2, 1);
    idle(8);
    bus_rd(32'h1C, 32'd1, "t6_pre_clr_drop");
    bus_rd(32'h20, 32'd1, "t6_pre_clr_pos");
    idle(2);
    droplet(100, 100, 5, 0, f);
    expect_pulse(f + 2, 1);
    @(negedge clk);
    bus_wr(32'h00, 32'd3);
    idle(8);
    bus_rd(32'h1C, 32'd0, "t6_clr_drop");
    bus_rd(32'h20, 32'd0, "t6_clr_pos");
    bus_rd(32'h00, 32'd1, "t6_ctrl_clr_reads0");

    // Unmapped and read-only accesses
    bus_rd(32'h30, 32'd0, "unmapped_read");
    bus_wr(32'h1C, 32'd5);
    bus_rd(32'h1C, 32'd0, "ro_write_ignored");
    check("err_const", {31'd0, sys_err}, 32'd0);

    idle(5);
    check("pending_pulses", 32'(rise_q.size()), 32'd0);
    check("pending_bus", 32'(bus_read_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
